// File: rtl/aars_spi_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Holds the FSM state encoding, the command read/write bit position and the default address width.
package aars_spi_pkg;

  localparam int AARS_ADDR_W_DEF = 7;
  localparam int CMD_RW_BIT      = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RFETCH = 3'd3,
    RLATCH = 3'd4,
    RWAIT  = 3'd5
  } state_e;

endpackage

// File: rtl/aars_spi_reg_ctrl.sv
// SPI byte stream to register bus bridge: cmd byte, then write data or read-back; write strobe 1 cycle after rx, tx_load 3 cycles after read cmd.
// No backpressure: bytes arriving during a read fetch are dropped and flagged; AARS_SPI_AUTOINC_EN enables burst address auto-increment.
module aars_spi_reg_ctrl
  import aars_spi_pkg::*;
#(
  parameter int ADDR_W   = AARS_ADDR_W_DEF,
  parameter int RST_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wr_data,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  output logic              busy,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RST_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              cs_prev_q;
  logic              cs_rise;
  logic              rx_fire;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;

  assign cs_rise = cs_active & ~cs_prev_q;
  // A byte is only acted on while the frame is still open.
  assign rx_fire = rx_valid & cs_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!cs_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_rise) state_d = CMD;
        CMD:     if (rx_valid) state_d = rx_data[CMD_RW_BIT] ? RFETCH : WDATA;
        WDATA:   state_d = WDATA;
        RFETCH:  state_d = RLATCH;
        RLATCH:  state_d = RWAIT;
        RWAIT:   if (rx_valid) state_d = RFETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    reg_rd_en = (state_q == RFETCH);
  end

  always_comb begin
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;

`ifdef AARS_SPI_AUTOINC_EN
    // Step after the strobe has used the address, so each strobe sees a stable address.
    if (wr_en_q && (state_q == WDATA)) addr_d = addr_q + ONE_A;
    if ((state_q == RWAIT) && rx_fire) addr_d = addr_q + ONE_A;
`endif

    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          addr_d = RST_A;
          ovf_d  = 1'b0;
        end
      end
      CMD: begin
        if (rx_fire) addr_d = ADDR_W'(rx_data);
      end
      WDATA: begin
        if (rx_fire) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_data;
        end
      end
      RFETCH: begin
        if (rx_fire) ovf_d = 1'b1;
      end
      RLATCH: begin
        if (rx_fire) ovf_d = 1'b1;
        if (cs_active) begin
          tx_data_d = reg_rd_data;
          tx_load_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // cs_prev_q resets high so a chip select already asserted at reset release is not taken as a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q <= 1'b1;
      addr_q    <= RST_A;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      cs_prev_q <= cs_active;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign reg_addr    = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_load     = tx_load_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign err_ovf     = ovf_q;

endmodule

// File: tb/tb_aars_spi_reg_ctrl.sv
// Bench for aars_spi_reg_ctrl: byte-level frame model against an emulated register file.
// Directed bursts, wrap, abort, overrun and reset cases followed by randomized frames.
`timescale 1ns/1ps
module tb_aars_spi_reg_ctrl;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef AARS_SPI_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs_active;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              busy;
  logic              err_ovf;

  always #5 clk = ~clk;

  aars_spi_reg_ctrl #(.ADDR_W(ADDR_W), .RST_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .busy(busy), .err_ovf(err_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 29) ^ 8'h5A);
  endfunction

  // Emulated external register file; read data valid the cycle after reg_rd_en.
  logic [7:0] rf [DEPTH];
  logic       fill;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= init_val(i);
    end else if (reg_wr_en) begin
      rf[reg_addr] <= reg_wr_data;
    end
    if (reg_rd_en) reg_rd_data <= rf[reg_addr];
  end

  // Reference register contents as the frame model believes them to be.
  logic [7:0] mdl [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         last_rx_cyc = -10;
  logic [7:0] obs_wa[$], obs_wd[$], obs_tx[$];
  int         obs_tc[$];
  logic [7:0] exp_wa[$], exp_wd[$], exp_tx[$];
  logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_tx = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        obs_wa.push_back(8'(reg_addr));
        obs_wd.push_back(reg_wr_data);
        check("wr_single_cycle", 32'(prev_wr), 32'd0);
        check("wr_latency", 32'(cyc), 32'(last_rx_cyc + 1));
      end
      if (reg_wr_en || reg_rd_en) check("wr_rd_exclusive", 32'(reg_wr_en & reg_rd_en), 32'd0);
      if (reg_rd_en) check("rd_single_cycle", 32'(prev_rd), 32'd0);
      if (tx_load) begin
        obs_tx.push_back(tx_data);
        obs_tc.push_back(cyc);
        check("tx_single_cycle", 32'(prev_tx), 32'd0);
      end
    end
    prev_wr = reg_wr_en;
    prev_rd = reg_rd_en;
    prev_tx = tx_load;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid    = 1'b1;
    rx_data     = b;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic clear_obs();
    obs_wa.delete(); obs_wd.delete(); obs_tx.delete(); obs_tc.delete();
    exp_wa.delete(); exp_wd.delete(); exp_tx.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_tx_load"}, 32'(tx_load), 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_wr_en"}, 32'(reg_wr_en), 32'd0);
    check({tag, "_wr_data"}, 32'(reg_wr_data), 32'h00);
    check({tag, "_rd_en"}, 32'(reg_rd_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  // Model a whole frame from its bytes, drive it with byte spacing >= 3 cycles, then compare.
  task automatic run_frame(input byte_q_t b);
    int a;
    int cmd_cyc;
    bit rd;
    rd = b[0][7];
    a  = int'(b[0]) % DEPTH;
    if (!rd) begin
      for (int i = 1; i < b.size(); i++) begin
        exp_wa.push_back(8'(a));
        exp_wd.push_back(b[i]);
        mdl[a] = b[i];
        a = (a + INC) % DEPTH;
      end
    end else begin
      exp_tx.push_back(mdl[a]);
      for (int i = 1; i < b.size(); i++) begin
        a = (a + INC) % DEPTH;
        exp_tx.push_back(mdl[a]);
      end
    end
    cs_active = 1'b1;
    tick(2);
    check("busy_in_frame", 32'(busy), 32'd1);
    cmd_cyc = cyc;
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i]);
      tick($urandom_range(4, 2));
    end
    tick(4);
    check("ovf_clear", 32'(err_ovf), 32'd0);
    cs_active = 1'b0;
    tick(3);
    check("n_writes", 32'(obs_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
      check("wr_addr", 32'(obs_wa[i]), 32'(exp_wa[i]));
      check("wr_data", 32'(obs_wd[i]), 32'(exp_wd[i]));
    end
    check("n_tx", 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      check("tx_data", 32'(obs_tx[i]), 32'(exp_tx[i]));
    if (rd && obs_tc.size() > 0) check("tx_first_latency", 32'(obs_tc[0] - cmd_cyc), 32'd3);
    clear_obs();
  endtask

  initial begin
    byte_q_t q;
    int      ncmd;
    rst_n     = 1'b0;
    cs_active = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    fill      = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = init_val(i);
    #1;
    check_reset_vals("rst");
    tick(3);
    fill  = 1'b0;
    rst_n = 1'b1;
    tick(2);

    rx_valid = 1'b1;
    rx_data  = 8'h05;
    tick(1);
    rx_valid = 1'b0;
    check("idle_rx_ignored", 32'(busy), 32'd0);

    q = {8'h05, 8'hAA, 8'hBB};
    run_frame(q);
    q = {8'h03, 8'h11};
    run_frame(q);
    q = {8'h04, 8'h22};
    run_frame(q);
    q = {8'h83, 8'h00, 8'h00};
    run_frame(q);
    q = {8'h7F, 8'hC1, 8'hC2};
    run_frame(q);
    q = {8'h02, 8'h10, 8'h20};
    run_frame(q);

    // Chip select drops together with a data byte: the byte must not be written.
    cs_active = 1'b1;
    tick(2);
    send_byte(8'h05);
    tick(2);
    rx_valid  = 1'b1;
    rx_data   = 8'h99;
    cs_active = 1'b0;
    tick(1);
    rx_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    tick(3);
    check("abort_no_write", 32'(obs_wa.size()), 32'd0);
    clear_obs();

    // Byte during the fetch is dropped and the error sticks until the next frame start.
    cs_active = 1'b1;
    tick(2);
    send_byte(8'h83);
    send_byte(8'h5C);
    check("ovf_set", 32'(err_ovf), 32'd1);
    tick(5);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    check("ovf_n_tx", 32'(obs_tx.size()), 32'd1);
    if (obs_tx.size() > 0) check("ovf_tx_data", 32'(obs_tx[0]), 32'(mdl[3]));
    cs_active = 1'b0;
    tick(3);
    check("ovf_after_frame", 32'(err_ovf), 32'd1);
    cs_active = 1'b1;
    tick(1);
    check("ovf_cleared_new_frame", 32'(err_ovf), 32'd0);
    cs_active = 1'b0;
    tick(3);
    clear_obs();

    // Reset in the middle of a read with an overrun pending.
    cs_active = 1'b1;
    tick(2);
    send_byte(8'h83);
    send_byte(8'h3C);
    tick(2);
    check("pre_rst_tx_data", 32'(tx_data), 32'h11);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("no_restart_without_edge", 32'(busy), 32'd0);
    cs_active = 1'b0;
    tick(3);
    clear_obs();

    for (int f = 0; f < 24; f++) begin
      ncmd = (f % 5 == 0) ? (DEPTH - 1) : int'($urandom_range(DEPTH - 1, 0));
      q = {};
      q.push_back({1'($urandom_range(1, 0)), 7'(ncmd)});
      for (int i = 0; i < int'($urandom_range(4, 1)); i++) q.push_back(8'($urandom));
      run_frame(q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
